uart_rx_block_ctrl: RTL and testbench
=====================================

Name: uart_rx_block_ctrl

Overview:
Controller that sequences the UART byte receiver and assembles its bytes into fixed-size key or data blocks for the encryption core. It consumes each received byte via the receiver's ready/clear handshake. It parses a one-byte header selecting key vs data and shifts in NBYTES payload bytes. It presents the finished block on a valid/ready interface, with pulsed error flags for bad headers, inter-byte timeout and overrun.

Parameters:
NBYTES, 16, payload bytes per block (>=2); block width = 8*NBYTES
TIMEOUT_CYC, 500000, max clk_50m cycles between payload bytes (10 ms at 50 MHz)
HDR_KEY, 8'h4B, header byte selecting key block
HDR_DATA, 8'h44, header byte selecting data block

Ports:
clk_50m  in  1  system clock, single clock domain
rst  in  1  reset; synchronous, active-high
rx_rdy  in  1  receiver byte-ready flag (level, held until cleared)
rx_data  in  8  receiver byte, valid while rx_rdy=1
rx_rdy_clr  out  1  one-cycle clear pulse to receiver
blk_valid  out  1  block available
blk_ready  in  1  downstream accepts block
blk_is_key  out  1  1 = key block, 0 = data block; valid with blk_valid
blk_data  out  8*NBYTES  assembled block, first payload byte in MSBs
busy  out  1  1 in PAYLOAD or HOLD
bad_hdr  out  1  one-cycle pulse: non-header byte received in IDLE
to_err  out  1  one-cycle pulse: payload timeout, partial block dropped
ovr_err  out  1  one-cycle pulse: byte dropped while in HOLD

Behaviour:
- All outputs and state are registered. Reset (rst=1 at clk_50m edge, any state): state=IDLE; blk_valid=0; blk_is_key=0; blk_data=0; rx_rdy_clr=0; error pulses=0; byte counter, guard and timeout counters=0.
- Byte accept: occurs when rx_rdy=1 and guard=0. On accept, rx_data is captured, rx_rdy_clr=1 next cycle only, and guard is loaded with 2. Guard decrements per cycle. This masks the stale rx_rdy still high during the 2-cycle clear round trip.
- IDLE: on accept:
  - rx_data==HDR_KEY: blk_is_key<=1, count<=0, go to PAYLOAD.
  - rx_data==HDR_DATA: blk_is_key<=0, count<=0, go to PAYLOAD.
  - Any other value: bad_hdr pulse; stay in IDLE.
- PAYLOAD: on accept, blk_data<={blk_data[8*NBYTES-9:0], rx_data}, count+1, timeout counter<=0.
  - When the byte accepted is number NBYTES (count==NBYTES-1), go to HOLD and set blk_valid=1 on the next cycle.
  - Without an accept, the timeout counter increments. When it reaches TIMEOUT_CYC-1: to_err pulse, go to IDLE, count<=0. blk_data is left as is and is not valid.
  - Accept and timeout terminal value in the same cycle: the accept wins.
- HOLD: blk_valid=1; blk_data and blk_is_key are stable until the handshake.
  - blk_ready=1: blk_valid<=0, go to IDLE.
  - Accept while blk_ready=0: byte discarded, rx_rdy_clr still pulsed, ovr_err pulse.
  - Accept in the same cycle as blk_ready=1: the byte is evaluated as an IDLE header byte (may go straight to PAYLOAD).
- Timeout counter: width clog2(TIMEOUT_CYC)+1. It runs only in PAYLOAD and is cleared on every state entry.
- Byte counter width: clog2(NBYTES)+1; no wrap beyond NBYTES-1.
- Latency: last payload byte accept edge to blk_valid=1 is 1 cycle. blk_ready high to blk_valid low is 1 cycle.
- Never more than one rx_rdy_clr pulse per received byte. rx_rdy_clr is never asserted while rx_rdy=0 except inside the guard window.

Test Plan:
- NBYTES=4: bytes 4B,11,22,33,44 with rx_rdy level-held until cleared -> five rx_rdy_clr pulses; blk_valid=1, blk_is_key=1, blk_data=32'h11223344; hold blk_ready=0 for 10 cycles -> outputs stable; blk_ready=1 -> blk_valid=0 next cycle.
- Bytes 41 then 44,AA,BB,CC,DD -> bad_hdr single pulse for 41; block blk_is_key=0, blk_data=32'hAABBCCDD.
- TIMEOUT_CYC=100: 44,01,02 then silence -> to_err pulse exactly 100 cycles after byte 02 accepted; state IDLE. Next 44,05,06,07,08 -> blk_data=32'h05060708.
- Block held in HOLD (blk_ready=0), byte 4B arrives -> ovr_err pulse, rx_rdy_clr pulse, block unchanged. Byte 4B coincident with blk_ready=1 -> handoff completes and busy stays 1 (PAYLOAD entered).
- rst=1 for one cycle mid-PAYLOAD after 2 bytes -> all outputs 0. Next 4B + 4 bytes forms a full block with no leftover bytes.
- rx_rdy held high continuously (second byte arriving during clear) -> exactly one accept per guard window, no double capture.

Source files
------------

// File: rtl/uart_rx_block_ctrl.sv
// Sequences the UART byte receiver and assembles received bytes into fixed-size
// key or data blocks for the encryption core.
//
// A one-byte header (HDR_KEY / HDR_DATA) opens a block. NBYTES payload bytes are
// then shifted in, first byte ending up in the MSBs. The block is offered on a
// valid/ready interface.
//
// Ports:
//   clk_50m     system clock
//   rst         synchronous active-high reset
//   rx_rdy      receiver byte-ready level, held until cleared
//   rx_data     receiver byte, valid while rx_rdy=1
//   rx_rdy_clr  one-cycle clear pulse back to the receiver
//   blk_valid   assembled block available
//   blk_ready   downstream accepts the block
//   blk_is_key  1 = key block, 0 = data block (valid with blk_valid)
//   blk_data    assembled block
//   busy        collecting payload or holding a block
//   bad_hdr     pulse: non-header byte received while idle
//   to_err      pulse: inter-byte payload timeout, partial block dropped
//   ovr_err     pulse: byte dropped while a block is held
module uart_rx_block_ctrl #(
  parameter int unsigned NBYTES      = 16,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter logic [7:0]  HDR_KEY     = 8'h4B,
  parameter logic [7:0]  HDR_DATA    = 8'h44
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic                rx_rdy,
  input  logic [7:0]          rx_data,
  output logic                rx_rdy_clr,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic                blk_is_key,
  output logic [8*NBYTES-1:0] blk_data,
  output logic                busy,
  output logic                bad_hdr,
  output logic                to_err,
  output logic                ovr_err
);

  localparam int unsigned BW   = 8 * NBYTES;
  localparam int unsigned CntW = $clog2(NBYTES) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NBYTES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StPayload, StHold} state_e;

  state_e          state_q, state_d;
  logic [1:0]      guard_q, guard_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [BW-1:0]   data_q, data_d;
  logic            key_q, key_d;
  logic            clr_q, clr_d;
  logic            bad_q, bad_d;
  logic            to_q, to_d;
  logic            ovr_q, ovr_d;

  logic accept, hdr_key, hdr_data, hdr_ok, tmo_hit, last_byte;

  // The guard masks rx_rdy while the clear pulse makes its round trip to the
  // receiver, so a stale level is never taken as a new byte.
  assign accept    = rx_rdy && (guard_q == 2'd0);
  assign hdr_key   = (rx_data == HDR_KEY);
  assign hdr_data  = (rx_data == HDR_DATA);
  assign hdr_ok    = hdr_key || hdr_data;
  assign tmo_hit   = (tmo_q == TmoLast);
  assign last_byte = (cnt_q == CntLast);

  // State register
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= StIdle;
      guard_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      key_q   <= 1'b0;
      clr_q   <= 1'b0;
      bad_q   <= 1'b0;
      to_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      key_q   <= key_d;
      clr_q   <= clr_d;
      bad_q   <= bad_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept && hdr_ok) state_d = StPayload;
      end
      StPayload: begin
        // An accept beats a coincident timeout.
        if (accept) begin
          if (last_byte) state_d = StHold;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StHold: begin
        // A byte arriving with the handoff is treated as a fresh header.
        if (blk_ready) state_d = (accept && hdr_ok) ? StPayload : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output logic
  always_comb begin
    guard_d = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    if (accept) guard_d = 2'd2;
    clr_d  = accept;
    bad_d  = 1'b0;
    to_d   = 1'b0;
    ovr_d  = 1'b0;
    cnt_d  = cnt_q;
    tmo_d  = '0;  // cleared on every state entry; only counts while collecting
    data_d = data_q;
    key_d  = key_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (hdr_ok) begin
            key_d = hdr_key;
            cnt_d = '0;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      StPayload: begin
        if (accept) begin
          data_d = {data_q[BW-9:0], rx_data};
          cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
        end else if (tmo_hit) begin
          to_d  = 1'b1;
          cnt_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StHold: begin
        if (blk_ready) begin
          if (accept) begin
            if (hdr_ok) begin
              key_d = hdr_key;
              cnt_d = '0;
            end else begin
              bad_d = 1'b1;
            end
          end
        end else if (accept) begin
          ovr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rx_rdy_clr = clr_q;
  assign blk_valid  = (state_q == StHold);
  assign busy       = (state_q != StIdle);
  assign blk_is_key = key_q;
  assign blk_data   = data_q;
  assign bad_hdr    = bad_q;
  assign to_err     = to_q;
  assign ovr_err    = ovr_q;

endmodule

// File: tb/tb_uart_rx_block_ctrl.sv
// Bench for uart_rx_block_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model (accept timestamps, byte history).
module tb_uart_rx_block_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned TO = 100;
  localparam logic [7:0]  HK = 8'h4B;
  localparam logic [7:0]  HD = 8'h44;

  logic            clk_50m = 1'b0;
  logic            rst, rx_rdy, blk_ready;
  logic [7:0]      rx_data;
  logic            rx_rdy_clr, blk_valid, blk_is_key, busy, bad_hdr, to_err, ovr_err;
  logic [8*NB-1:0] blk_data;

  uart_rx_block_ctrl #(
    .NBYTES     (NB),
    .TIMEOUT_CYC(TO),
    .HDR_KEY    (HK),
    .HDR_DATA   (HD)
  ) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .rx_rdy_clr(rx_rdy_clr),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_is_key(blk_is_key),
    .blk_data  (blk_data),
    .busy      (busy),
    .bad_hdr   (bad_hdr),
    .to_err    (to_err),
    .ovr_err   (ovr_err)
  );

  always #5 clk_50m = ~clk_50m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  int              cyc = 0;
  int              m_mode = 0;      // 0 idle, 1 collecting, 2 holding
  logic            m_key = 1'b0;
  int              m_n = 0;
  int              m_last_acc = -100;
  int              m_ref = 0;       // cycle of last payload progress
  logic [7:0]      hist[$];         // last NB payload bytes since reset
  logic [8*NB-1:0] e_data;
  logic            e_clr, e_bad, e_to, e_ovr, acc;
  logic            s_rst, s_rdy, s_brdy;
  logic [7:0]      s_dat;
  int              last_clr_cyc = -1, to_err_cyc = -1;
  int              clr_cnt = 0, bad_cnt = 0, ovr_cnt = 0;

  initial begin
    forever begin
      @(posedge clk_50m);
      s_rst = rst; s_rdy = rx_rdy; s_dat = rx_data; s_brdy = blk_ready;
      cyc++;
      e_clr = 1'b0; e_bad = 1'b0; e_to = 1'b0; e_ovr = 1'b0;
      if (s_rst) begin
        m_mode = 0; m_key = 1'b0; m_n = 0; m_last_acc = -100; m_ref = cyc;
        hist.delete();
      end else begin
        // a byte is taken when ready and at least 3 cycles after the previous one
        acc = s_rdy && (cyc - m_last_acc >= 3);
        if (acc) begin
          m_last_acc = cyc;
          e_clr = 1'b1;
        end
        if (m_mode == 1) begin
          if (acc) begin
            hist.push_back(s_dat);
            if (hist.size() > NB) void'(hist.pop_front());
            m_n++;
            m_ref = cyc;
            if (m_n == NB) m_mode = 2;
          end else if (cyc - m_ref == TO) begin
            e_to = 1'b1;
            m_mode = 0;
          end
        end else if (m_mode == 2 && !s_brdy) begin
          if (acc) e_ovr = 1'b1;
        end else begin
          m_mode = 0;
          if (acc) begin
            if (s_dat == HK || s_dat == HD) begin
              m_key = (s_dat == HK);
              m_mode = 1; m_n = 0; m_ref = cyc;
            end else begin
              e_bad = 1'b1;
            end
          end
        end
      end
      e_data = '0;
      for (int i = 0; i < hist.size(); i++) e_data = {e_data[8*NB-9:0], hist[i]};
      #1;
      chk("rx_rdy_clr", rx_rdy_clr, e_clr);
      chk("blk_valid", blk_valid, m_mode == 2);
      chk("busy", busy, m_mode != 0);
      chk("blk_is_key", blk_is_key, m_key);
      chk("blk_data", blk_data, e_data);
      chk("bad_hdr", bad_hdr, e_bad);
      chk("to_err", to_err, e_to);
      chk("ovr_err", ovr_err, e_ovr);
      if (rx_rdy_clr) begin last_clr_cyc = cyc; clr_cnt++; end
      if (to_err) to_err_cyc = cyc;
      if (bad_hdr) bad_cnt++;
      if (ovr_err) ovr_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 0;  // blk_ready: 0 low, 1 high, 2 random

  initial begin
    blk_ready = 1'b0;
    forever begin
      @(negedge clk_50m);
      #1;
      case (rdy_mode)
        0:       blk_ready = 1'b0;
        1:       blk_ready = 1'b1;
        default: blk_ready = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  // Receiver: hold the byte until the clear is seen, drop one cycle later.
  task automatic send_byte(input logic [7:0] b, input bit keep_high);
    bit got = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_50m);
      if (rx_rdy_clr) got = 1'b1;
    end
    if (!got) chk("clr_wait", 0, 1);
    @(negedge clk_50m);
    if (!keep_high) rx_rdy = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] b0, b1, b2, b3, b4);
    logic [7:0] s[5];
    s[0] = b0; s[1] = b1; s[2] = b2; s[3] = b3; s[4] = b4;
    for (int i = 0; i < 5; i++) begin
      send_byte(s[i], 1'b0);
      idle(2);
    end
  endtask

  task automatic release_blk();
    rdy_mode = 1;
    idle(1);
    chk("valid_drop", blk_valid, 0);
    rdy_mode = 0;
    idle(1);
  endtask

  int c0, b0, o0;
  logic [7:0] rb;
  bit k;

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
    idle(3);
    chk("rst_valid", blk_valid, 0);
    chk("rst_key", blk_is_key, 0);
    chk("rst_data", blk_data, 0);
    chk("rst_clr", rx_rdy_clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {bad_hdr, to_err, ovr_err}, 0);
    rst = 1'b0;
    idle(2);

    // key block, then hold stable
    c0 = clr_cnt;
    send_seq(8'h4B, 8'h11, 8'h22, 8'h33, 8'h44);
    chk("s1_clr_count", clr_cnt - c0, 5);
    chk("s1_valid", blk_valid, 1);
    chk("s1_key", blk_is_key, 1);
    chk("s1_data", blk_data, 32'h11223344);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("s1_hold_data", blk_data, 32'h11223344);
    end
    release_blk();

    // bad header then data block
    b0 = bad_cnt;
    send_byte(8'h41, 1'b0);
    idle(2);
    send_seq(8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    chk("s2_bad_count", bad_cnt - b0, 1);
    chk("s2_key", blk_is_key, 0);
    chk("s2_data", blk_data, 32'hAABBCCDD);
    release_blk();

    // timeout
    send_byte(8'h44, 1'b0); idle(2);
    send_byte(8'h01, 1'b0); idle(2);
    send_byte(8'h02, 1'b0);
    idle(105);
    chk("s3_to_latency", to_err_cyc - last_clr_cyc, 100);
    chk("s3_idle", busy, 0);
    send_seq(8'h44, 8'h05, 8'h06, 8'h07, 8'h08);
    chk("s3_data", blk_data, 32'h05060708);

    // overrun while held, then header coincident with handoff
    o0 = ovr_cnt;
    c0 = clr_cnt;
    send_byte(8'h4B, 1'b0);
    idle(3);
    chk("s4_ovr_count", ovr_cnt - o0, 1);
    chk("s4_clr_count", clr_cnt - c0, 1);
    chk("s4_data_kept", blk_data, 32'h05060708);
    chk("s4_still_valid", blk_valid, 1);
    rdy_mode = 1;
    send_byte(8'h4B, 1'b0);
    rdy_mode = 0;
    chk("s4_busy", busy, 1);
    chk("s4_valid", blk_valid, 0);
    chk("s4_key", blk_is_key, 1);

    // reset mid-payload
    send_byte(8'hA1, 1'b0); idle(2);
    send_byte(8'hA2, 1'b0); idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_data", blk_data, 0);
    chk("s5_rst_key", blk_is_key, 0);
    send_seq(8'h4B, 8'h01, 8'h02, 8'h03, 8'h04);
    chk("s5_data", blk_data, 32'h01020304);
    chk("s5_valid", blk_valid, 1);
    release_blk();

    // rx_rdy held high across consecutive bytes
    c0 = clr_cnt;
    send_byte(8'h44, 1'b1);
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hC4, 1'b0);
    idle(2);
    chk("s6_clr_count", clr_cnt - c0, 5);
    chk("s6_data", blk_data, 32'hC1C2C3C4);
    chk("s6_key", blk_is_key, 0);
    release_blk();

    // randomized traffic
    rdy_mode = 2;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rb = HK;
        3, 4, 5: rb = HD;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      k = ($urandom_range(0, 3) == 0);
      send_byte(rb, k);
      if (!k) begin
        if ($urandom_range(0, 19) == 0) idle(105);
        else idle($urandom_range(0, 4));
        if ($urandom_range(0, 49) == 0) begin
          rst = 1'b1;
          idle(1);
          rst = 1'b0;
        end
      end
    end
    rx_rdy = 1'b0;
    rdy_mode = 1;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1);
  end

endmodule
